cr_cddip_support_quiesce_ctl: RTL and testbench

//  Admission and quiesce controller for the CDDIP pipe. Gates new RQE admission into the ISF,

---
 rtl/cr_cddip_support_quiesce_ctl.sv | 112 +++++++++++
 tb/tb_cr_cddip_support_quiesce_ctl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cr_cddip_support_quiesce_ctl.sv
// Admission/quiesce controller for the CDDIP pipe: gates RQE admission, tracks outstanding
// commands against a credit limit and drains the pipe on quiesce request with optional timeout.
module cr_cddip_support_quiesce_ctl #(
  parameter int MAX_OUTSTANDING = 32,
  parameter int TMO_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             isf_sup_rqe_rx,
  input  logic             osf_sup_cqe_exit,
  input  logic             quiesce_req,
  input  logic             resume_req,
  input  logic             auto_quiesce_en,
  input  logic             pre_cddip_int,
  input  logic [TMO_W-1:0] drain_tmo,
  output logic             sup_isf_admit_en,
  output logic             quiesce_ack,
  output logic             drain_tmo_int,
  output logic             cnt_err,
  output logic [1:0]       qstate,
  output logic [7:0]       outstanding
);

  // state    | meaning
  // RUN      | admitting RQEs while credits remain
  // DRAIN    | admission closed, waiting for outstanding to reach 0
  // QUIESCED | pipe empty, admission closed, waiting for resume
  // TIMEOUT  | drain timer expired with commands still outstanding
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [TMO_W-1:0] tmo_m1;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_d, tmo_hit, qreq;

  assign qreq   = quiesce_req | (auto_quiesce_en & pre_cddip_int);
  assign tmo_m1 = drain_tmo - TMO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      timer_q       <= '0;
      cnt_q         <= '0;
      drain_tmo_int <= 1'b0;
      cnt_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      drain_tmo_int <= tmo_hit;
      cnt_err       <= err_d;
    end
  end

  // Violating RQEs (admit closed) are still counted so the drain stays accurate.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    case ({isf_sup_rqe_rx, osf_sup_cqe_exit})
      2'b10: if (cnt_q == 8'hFF) err_d = 1'b1; else cnt_d = cnt_q + 8'd1;
      2'b01: if (cnt_q == 8'h00) err_d = 1'b1; else cnt_d = cnt_q - 8'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tmo_hit = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (qreq) begin
          state_d = ST_DRAIN;
          timer_d = '0;
        end
      end
      ST_DRAIN: begin
        // An empty pipe wins over a timeout landing on the same cycle.
        if (cnt_q == 8'h00) begin
          state_d = ST_QUIESCED;
        end else if ((drain_tmo != '0) && (timer_q == tmo_m1)) begin
          state_d = ST_TIMEOUT;
          tmo_hit = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end
      ST_QUIESCED: begin
        if (resume_req && !qreq) state_d = ST_RUN;
      end
      ST_TIMEOUT: begin
        if (cnt_q == 8'h00)            state_d = ST_QUIESCED;
        else if (resume_req && !qreq)  state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign sup_isf_admit_en = (state_q == ST_RUN) && (cnt_q < MAX_CNT);
  assign quiesce_ack      = (state_q == ST_QUIESCED);
  assign qstate           = state_q;
  assign outstanding      = cnt_q;

endmodule

// File: tb/tb_cr_cddip_support_quiesce_ctl.sv
// Bench for cr_cddip_support_quiesce_ctl (credit limit 4): vector table through a scoreboard
// queue, plus a hand-written asynchronous reset sequence.
module tb_cr_cddip_support_quiesce_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0, ex = 1'b0, qr = 1'b0, rs = 1'b0, aen = 1'b0, pint = 1'b0;
  logic [15:0] tmo = '0;
  logic        admit, ack, tmo_int, cerr;
  logic [1:0]  qs;
  logic [7:0]  cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cr_cddip_support_quiesce_ctl #(.MAX_OUTSTANDING(4), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .isf_sup_rqe_rx(rx), .osf_sup_cqe_exit(ex),
    .quiesce_req(qr), .resume_req(rs),
    .auto_quiesce_en(aen), .pre_cddip_int(pint), .drain_tmo(tmo),
    .sup_isf_admit_en(admit), .quiesce_ack(ack), .drain_tmo_int(tmo_int),
    .cnt_err(cerr), .qstate(qs), .outstanding(cnt)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       adm;
    logic [1:0] qs;
    logic       ack;
    logic       ti;
    logic       ce;
  } exp_t;

  typedef struct {
    logic        rx, ex, qr, rs, aen, pint;
    logic [15:0] tmo;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic v_rx, input logic v_ex, input logic v_qr,
                              input logic v_rs, input logic v_aen, input logic v_pint,
                              input logic [15:0] v_tmo, input logic [7:0] e_cnt,
                              input logic e_adm, input logic [1:0] e_qs,
                              input logic e_ti, input logic e_ce);
    vec_t v;
    v.rx = v_rx; v.ex = v_ex; v.qr = v_qr; v.rs = v_rs; v.aen = v_aen; v.pint = v_pint;
    v.tmo = v_tmo;
    v.e.cnt = e_cnt; v.e.adm = e_adm; v.e.qs = e_qs; v.e.ack = (e_qs == 2'd2);
    v.e.ti = e_ti; v.e.ce = e_ce;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t g, e;
    @(negedge clk);
    rx = v.rx; ex = v.ex; qr = v.qr; rs = v.rs; aen = v.aen; pint = v.pint; tmo = v.tmo;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    g = '{cnt: cnt, adm: admit, qs: qs, ack: ack, ti: tmo_int, ce: cerr};
    if (sb.size() == 0) begin
      chk($sformatf("vec%0d_sb_empty", idx), 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("vec%0d{cnt,adm,qs,ack,ti,ce}", idx), 32'(g), 32'(e));
    end
  endtask

  initial begin
    // credit limit: 4 outstanding closes admission, 1 exit reopens it
    add(1,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,0,0, 2,1,0,0,0);
    add(1,0,0,0,0,0,0, 3,1,0,0,0);
    add(1,0,0,0,0,0,0, 4,0,0,0,0);
    add(0,0,0,0,0,0,0, 4,0,0,0,0);
    add(0,1,0,0,0,0,0, 3,1,0,0,0);
    // violating rx still counted; rx+exit holds
    add(1,0,0,0,0,0,0, 4,0,0,0,0);
    add(1,0,0,0,0,0,0, 5,0,0,0,0);
    add(1,1,0,0,0,0,0, 5,0,0,0,0);
    add(0,1,0,0,0,0,0, 4,0,0,0,0);
    add(0,1,0,0,0,0,0, 3,1,0,0,0);
    // quiesce with 3 outstanding, drain, resume dropped while qreq high
    add(0,0,1,0,0,0,0, 3,0,1,0,0);
    add(0,1,1,0,0,0,0, 2,0,1,0,0);
    add(0,1,1,0,0,0,0, 1,0,1,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0,0,0, 0,0,2,0,0);
    add(0,0,1,1,0,0,0, 0,0,2,0,0);
    add(0,0,0,1,0,0,0, 0,1,0,0,0);
    // rx in the cycle qreq is sampled is counted and drained
    add(1,0,1,0,0,0,0, 1,0,1,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0,0,0, 0,0,2,0,0);
    add(0,0,0,1,0,0,0, 0,1,0,0,0);
    // drain timeout 10 cycles after DRAIN entry, then late drain
    add(1,0,0,0,0,0,10, 1,1,0,0,0);
    add(1,0,0,0,0,0,10, 2,1,0,0,0);
    add(0,0,1,0,0,0,10, 2,0,1,0,0);
    for (int k = 1; k <= 9; k++) add(0,0,0,0,0,0,10, 2,0,1,0,0);
    add(0,0,0,0,0,0,10, 2,0,3,1,0);
    add(0,0,0,0,0,0,10, 2,0,3,0,0);
    add(0,1,0,0,0,0,10, 1,0,3,0,0);
    add(0,1,0,0,0,0,10, 0,0,3,0,0);
    add(0,0,0,0,0,0,10, 0,0,2,0,0);
    add(0,0,0,1,0,0,10, 0,1,0,0,0);
    // exit at zero
    add(0,1,0,0,0,0,0, 0,1,0,0,1);
    add(0,0,0,0,0,0,0, 0,1,0,0,0);
    // auto quiesce from interrupt
    add(0,0,0,0,0,1,0, 0,1,0,0,0);
    add(0,0,0,0,1,1,0, 0,0,1,0,0);
    add(0,0,0,0,1,1,0, 0,0,2,0,0);
    add(0,0,0,1,1,1,0, 0,0,2,0,0);
    add(0,0,0,0,1,0,0, 0,0,2,0,0);
    add(0,0,0,1,1,0,0, 0,1,0,0,0);
    // drain_tmo changed mid-drain; resume out of TIMEOUT with commands outstanding
    add(1,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,0,0, 2,1,0,0,0);
    add(1,0,0,0,0,0,0, 3,1,0,0,0);
    add(0,0,1,0,0,0,0, 3,0,1,0,0);
    for (int k = 1; k <= 5; k++) add(0,0,0,0,0,0,0, 3,0,1,0,0);
    add(0,0,0,0,0,0,3, 3,0,1,0,0);
    add(0,0,0,0,0,0,8, 3,0,1,0,0);
    add(0,0,0,0,0,0,8, 3,0,3,1,0);
    add(0,0,1,1,0,0,8, 3,0,3,0,0);
    add(0,0,0,1,0,0,8, 3,1,0,0,0);
    add(0,1,0,0,0,0,8, 2,1,0,0,0);
    add(0,1,0,0,0,0,8, 1,1,0,0,0);
    add(0,1,0,0,0,0,8, 0,1,0,0,0);
    // counter saturation at 255
    for (int i = 1; i <= 255; i++) add(1,0,0,0,0,0,0, 8'(i), (i < 4), 0,0,0);
    add(1,0,0,0,0,0,0, 255,0,0,0,1);
    add(0,0,0,0,0,0,0, 255,0,0,0,0);
    for (int i = 254; i >= 0; i--) add(0,1,0,0,0,0,0, 8'(i), (i < 4), 0,0,0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_admit_en", 32'(admit), 32'd1);
    chk("rst_quiesce_ack", 32'(ack), 32'd0);
    chk("rst_qstate", 32'(qs), 32'd0);
    chk("rst_outstanding", 32'(cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // asynchronous reset mid-DRAIN with 7 outstanding
    begin
      vec_t v;
      v.aen = 0; v.pint = 0; v.tmo = '0; v.rs = 0; v.ex = 0;
      for (int i = 1; i <= 7; i++) begin
        v.rx = 1; v.qr = 0;
        v.e = '{cnt: 8'(i), adm: (i < 4), qs: 2'd0, ack: 1'b0, ti: 1'b0, ce: 1'b0};
        apply(v, 9000 + i);
      end
      v.rx = 0; v.qr = 1;
      v.e = '{cnt: 8'd7, adm: 1'b0, qs: 2'd1, ack: 1'b0, ti: 1'b0, ce: 1'b0};
      apply(v, 9100);
      v.qr = 0;
      v.e = '{cnt: 8'd7, adm: 1'b0, qs: 2'd1, ack: 1'b0, ti: 1'b0, ce: 1'b0};
      apply(v, 9101);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_qstate", 32'(qs), 32'd0);
    chk("async_rst_outstanding", 32'(cnt), 32'd0);
    chk("async_rst_admit_en", 32'(admit), 32'd1);
    rx = 0; ex = 0; qr = 0; rs = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_admit_en", 32'(admit), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_qstate", 32'(qs), 32'd0);
    chk("post_rst_outstanding", 32'(cnt), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
